// File: rtl/awgn_noise_gen.sv
// awgn_noise_gen: approximate Gaussian noise from sums of uniform LFSR samples.
// Each channel adds NUM_SRC independent LFSR outputs (central limit), scales the
// sum by noise_mag/2^MAG_W and a further 2^-OUT_SHIFT, then saturates
// symmetrically. The pipeline is three stages with valid/ready backpressure.
`timescale 1ns/1ps

module awgn_noise_gen #(
    parameter int          DATA_W    = 12,
    parameter int          NUM_CH    = 2,
    parameter int          NUM_SRC   = 16,
    parameter int          MAG_W     = 8,
    parameter int          OUT_SHIFT = 2,
    parameter logic [31:0] SEED      = 32'h00C0_FFEE
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     enable,
    input  logic                     reseed,
    input  logic [MAG_W-1:0]         noise_mag,
    input  logic                     out_ready,
    output logic                     out_valid,
    output logic [NUM_CH*DATA_W-1:0] out_data,
    output logic [15:0]              sat_count
);

    localparam int SUM_W  = DATA_W + $clog2(NUM_SRC);
    localparam int PROD_W = SUM_W + MAG_W + 1;
    localparam int N_LFSR = NUM_CH * NUM_SRC;

    // Symmetric clip limits; the most negative code is deliberately excluded.
    localparam logic signed [PROD_W-1:0] POS_LIM = PROD_W'(2 ** (DATA_W - 1) - 1);
    localparam logic signed [PROD_W-1:0] NEG_LIM = -POS_LIM;

    // Primitive trinomial table x^W + x^TAP + 1, one entry per source index.
    // Every width is at least 15 so the low DATA_W bits are always available,
    // and at most 31 so a 32-bit seed always covers the whole register.
    function automatic int lfsr_width(input int k);
        case (k)
            0:       return 15;
            1:       return 17;
            2:       return 18;
            3:       return 20;
            4:       return 21;
            5:       return 22;
            6:       return 23;
            7:       return 25;
            8:       return 28;
            9:       return 29;
            10:      return 31;
            11:      return 17;
            12:      return 20;
            13:      return 23;
            14:      return 25;
            default: return 28;
        endcase
    endfunction

    function automatic int lfsr_tap(input int k);
        case (k)
            0:       return 14;
            1:       return 14;
            2:       return 11;
            3:       return 17;
            4:       return 19;
            5:       return 21;
            6:       return 18;
            7:       return 22;
            8:       return 25;
            9:       return 27;
            10:      return 28;
            11:      return 3;
            12:      return 3;
            13:      return 5;
            14:      return 3;
            default: return 3;
        endcase
    endfunction

    logic adv;
    logic s1_valid;
    logic s2_valid;
    logic clip_reg;

    logic signed [DATA_W-1:0] sample  [N_LFSR];
    logic signed [DATA_W-1:0] s1_data [N_LFSR];
    logic signed [SUM_W-1:0]  sum_next [NUM_CH];
    logic signed [SUM_W-1:0]  s2_sum   [NUM_CH];
    logic signed [PROD_W-1:0] prod     [NUM_CH];
    logic signed [PROD_W-1:0] shifted  [NUM_CH];
    logic signed [DATA_W-1:0] sat_next [NUM_CH];
    logic [NUM_CH-1:0]        clip_vec;

    // The whole pipeline, LFSRs included, moves only when the output slot frees.
    assign adv = !out_valid || out_ready;

    genvar gi;
    generate
        for (gi = 0; gi < N_LFSR; gi++) begin : g_src
            localparam int CH  = gi / NUM_SRC;
            localparam int K   = gi % NUM_SRC;
            localparam int W   = lfsr_width(K);
            localparam int TAP = lfsr_tap(K);
            localparam logic [31:0] MIXED = SEED ^ (32'(CH * 16 + K + 1) * 32'h9E37_79B9);
            localparam logic [W-1:0] SEED_W = (MIXED[W-1:0] == '0) ? W'(1) : MIXED[W-1:0];

            logic [W-1:0] state;

            // Fibonacci LFSR: reload seed on reset/reseed, step once per admitted sample.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    state <= SEED_W;
                end else if (reseed) begin
                    state <= SEED_W;
                end else if (adv && enable) begin
                    state <= {state[W-2:0], state[W-1] ^ state[TAP-1]};
                end
            end

            assign sample[gi] = state[DATA_W-1:0];
        end
    endgenerate

    // Stage 1: capture one uniform sample from every source.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            for (int i = 0; i < N_LFSR; i++) begin
                s1_data[i] <= '0;
            end
        end else if (reseed) begin
            s1_valid <= 1'b0;
        end else if (adv) begin
            s1_valid <= enable;
            if (enable) begin
                for (int i = 0; i < N_LFSR; i++) begin
                    s1_data[i] <= sample[i];
                end
            end
        end
    end

    // Per-channel sum of the sign-extended stage-1 samples.
    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            sum_next[c] = '0;
            for (int k = 0; k < NUM_SRC; k++) begin
                sum_next[c] = sum_next[c] + SUM_W'(s1_data[c * NUM_SRC + k]);
            end
        end
    end

    // Stage 2: register the channel sums.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            for (int c = 0; c < NUM_CH; c++) begin
                s2_sum[c] <= '0;
            end
        end else if (reseed) begin
            s2_valid <= 1'b0;
        end else if (adv) begin
            s2_valid <= s2_valid_in();
            for (int c = 0; c < NUM_CH; c++) begin
                s2_sum[c] <= sum_next[c];
            end
        end
    end

    function automatic logic s2_valid_in();
        return s1_valid;
    endfunction

    // Scale by the live noise_mag, floor-shift, and clip to the symmetric range.
    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            prod[c]     = s2_sum[c] * $signed({1'b0, noise_mag});
            shifted[c]  = prod[c] >>> (MAG_W + OUT_SHIFT);
            clip_vec[c] = 1'b0;
            sat_next[c] = shifted[c][DATA_W-1:0];
            if (shifted[c] > POS_LIM) begin
                sat_next[c] = POS_LIM[DATA_W-1:0];
                clip_vec[c] = 1'b1;
            end else if (shifted[c] < NEG_LIM) begin
                sat_next[c] = NEG_LIM[DATA_W-1:0];
                clip_vec[c] = 1'b1;
            end
        end
    end

    // Stage 3: output register plus the clip flag for this sample set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            clip_reg  <= 1'b0;
        end else if (reseed) begin
            out_valid <= 1'b0;
        end else if (adv) begin
            out_valid <= s2_valid;
            clip_reg  <= |clip_vec;
            for (int c = 0; c < NUM_CH; c++) begin
                out_data[c * DATA_W +: DATA_W] <= sat_next[c];
            end
        end
    end

    // Count accepted sample sets that clipped, sticking at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat_count <= '0;
        end else if (reseed) begin
            sat_count <= '0;
        end else if (out_valid && out_ready && clip_reg && (sat_count != 16'hFFFF)) begin
            sat_count <= sat_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_awgn_noise_gen.sv
// Testbench for awgn_noise_gen: a default instance exercised with random
// enable/ready traffic, resets and reseeds, plus a narrow high-gain instance
// that drives the clip counter into saturation.
`timescale 1ns/1ps

module tb_awgn_noise_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A: default parameters.
    logic        rst_n_a, en_a, reseed_a, rdy_a;
    logic [7:0]  mag_a;
    logic        valid_a;
    logic [23:0] data_a;
    logic [15:0] sat_a;

    // Instance B: 4-bit, 4 channels, no extra shift -> clips most of the time.
    logic        rst_n_b, en_b, reseed_b, rdy_b;
    logic [7:0]  mag_b;
    logic        valid_b;
    logic [15:0] data_b;
    logic [15:0] sat_b;

    awgn_noise_gen dut_a (
        .clk(clk), .rst_n(rst_n_a), .enable(en_a), .reseed(reseed_a),
        .noise_mag(mag_a), .out_ready(rdy_a), .out_valid(valid_a),
        .out_data(data_a), .sat_count(sat_a)
    );

    awgn_noise_gen #(.DATA_W(4), .NUM_CH(4), .OUT_SHIFT(0)) dut_b (
        .clk(clk), .rst_n(rst_n_b), .enable(en_b), .reseed(reseed_b),
        .noise_mag(mag_b), .out_ready(rdy_b), .out_valid(valid_b),
        .out_data(data_b), .sat_count(sat_b)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference model: trinomial table, per-source state, sample arithmetic.
    int tw [16] = '{15, 17, 18, 20, 21, 22, 23, 25, 28, 29, 31, 17, 20, 23, 25, 28};
    int tt [16] = '{14, 14, 11, 17, 19, 21, 18, 22, 25, 27, 28,  3,  3,  5,  3,  3};
    logic [31:0] mst [2][4][16];

    task automatic model_seed(input int m);
        logic [31:0] idx, s;
        for (int c = 0; c < 4; c++) begin
            for (int k = 0; k < 16; k++) begin
                idx = 32'(c * 16 + k + 1);
                s = 32'h00C0_FFEE ^ (idx * 32'h9E37_79B9);
                s = s & ((32'h1 << tw[k]) - 32'h1);
                if (s == 32'd0) s = 32'd1;
                mst[m][c][k] = s;
            end
        end
    endtask

    task automatic model_next(input int m, input int dw, input int nch, input int mag,
                              input int sh, output longint data, output bit clip);
        longint sum, v, p, lim;
        logic [31:0] s;
        int w, t;
        data = 0;
        clip = 1'b0;
        lim = (longint'(1) << (dw - 1)) - 1;
        for (int c = 0; c < nch; c++) begin
            sum = 0;
            for (int k = 0; k < 16; k++) begin
                s = mst[m][c][k];
                v = longint'(s) & ((longint'(1) << dw) - 1);
                if (v >= (longint'(1) << (dw - 1))) v = v - (longint'(1) << dw);
                sum += v;
                w = tw[k];
                t = tt[k];
                s = ((s << 1) | {31'd0, s[w-1] ^ s[t-1]}) & ((32'h1 << w) - 32'h1);
                mst[m][c][k] = s;
            end
            p = (sum * mag) >>> (8 + sh);
            if (p > lim) begin
                p = lim;
                clip = 1'b1;
            end else if (p < -lim) begin
                p = -lim;
                clip = 1'b1;
            end
            data = data | ((p & ((longint'(1) << dw) - 1)) << (c * dw));
        end
    endtask

    // Scoreboard state for instance A.
    int     sat_m, adm, acc;
    bit     stalled;
    longint held;
    real    s0, s1, q0, q1, x01;
    int     ns;
    bit     b_done = 1'b0;

    // Drive one negedge per cycle; mode 0 flow, 1 random, 2 drain, 3 stall.
    task automatic stream_a(input int ncyc, input int mode, input bit stats);
        longint exp_d;
        bit     clp;
        int     v0, v1;
        for (int i = 0; i < ncyc; i++) begin
            if (stalled) check_val("hold_data", data_a, held);
            case (mode)
                0: begin en_a = 1'b1; rdy_a = 1'b1; end
                1: begin
                    en_a  = ($urandom_range(0, 3) != 0);
                    rdy_a = (i < 5) ? 1'b0 : 1'($urandom_range(0, 1));
                end
                2: begin en_a = 1'b0; rdy_a = 1'b1; end
                default: begin en_a = 1'b1; rdy_a = 1'b0; end
            endcase
            if (valid_a && rdy_a) begin
                model_next(0, 12, 2, 255, 2, exp_d, clp);
                check_val("sat_count", sat_a, sat_m);
                check_val("sample", data_a, exp_d);
                if (clp && sat_m < 65535) sat_m++;
                acc++;
                $display("txn A %0d data=%h sat=%0d", acc, data_a, sat_a);
                if (stats) begin
                    v0 = int'($signed(data_a[11:0]));
                    v1 = int'($signed(data_a[23:12]));
                    s0 += v0; s1 += v1;
                    q0 += real'(v0) * v0; q1 += real'(v1) * v1;
                    x01 += real'(v0) * v1;
                    ns++;
                end
            end
            stalled = valid_a && !rdy_a;
            held    = data_a;
            if (en_a && (!valid_a || rdy_a)) adm++;
            @(negedge clk);
        end
    endtask

    task automatic restart_model();
        model_seed(0);
        sat_m = 0; adm = 0; acc = 0; stalled = 1'b0;
    endtask

    // Instance B: free-running, check samples early and the counter throughout.
    initial begin
        int n, post, satb;
        longint e;
        bit c;
        n = 0; post = 0; satb = 0;
        model_seed(1);
        wait (rst_n_b === 1'b1);
        for (int cy = 0; cy < 80000 && post < 300; cy++) begin
            @(negedge clk);
            if (valid_b) begin
                model_next(1, 4, 4, 255, 0, e, c);
                n++;
                if (n <= 400) check_val("b_sample", data_b, e);
                if ((n % 4096) == 0 || post > 0) begin
                    if ((n % 4096) == 0 || (post % 50) == 0) check_val("b_sat_count", sat_b, satb);
                end
                if (c && satb < 65535) satb++;
                if (satb == 65535) post++;
            end
        end
        if (post < 300) check_val("b_timeout", post, 300);
        @(negedge clk);
        check_val("b_sat_hold", sat_b, 65535);
        b_done = 1'b1;
    end

    initial begin
        real m0, m1, sd0, sd1, r;
        rst_n_a = 1'b0; en_a = 1'b0; reseed_a = 1'b0; rdy_a = 1'b0; mag_a = 8'd0;
        rst_n_b = 1'b0; en_b = 1'b1; reseed_b = 1'b0; rdy_b = 1'b1; mag_b = 8'd255;
        s0 = 0; s1 = 0; q0 = 0; q1 = 0; x01 = 0; ns = 0;
        restart_model();

        @(negedge clk);
        check_val("rst_valid", valid_a, 0);
        check_val("rst_data", data_a, 0);
        check_val("rst_sat", sat_a, 0);
        @(negedge clk);
        rst_n_a = 1'b1;
        rst_n_b = 1'b1;

        // Zero magnitude: three-cycle latency, then all-zero output.
        mag_a = 8'd0; en_a = 1'b1; rdy_a = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            check_val("latency_valid", valid_a, (i == 3));
        end
        for (int i = 0; i < 20; i++) begin
            check_val("zero_valid", valid_a, 1);
            check_val("zero_data", data_a, 0);
            @(negedge clk);
        end

        // Reset mid-stream, then random enable/ready traffic and a drain.
        #2 rst_n_a = 1'b0;
        #1 check_val("async_rst_valid", valid_a, 0);
        @(negedge clk);
        en_a = 1'b0; mag_a = 8'd255;
        restart_model();
        rst_n_a = 1'b1;
        stream_a(800, 1, 1'b0);
        stream_a(12, 2, 1'b0);
        check_val("drain_count", acc, adm);
        check_val("drain_idle", valid_a, 0);

        // Stream, then async reset with data and counter live.
        stream_a(40, 0, 1'b0);
        #2 rst_n_a = 1'b0;
        #1;
        check_val("midrst_valid", valid_a, 0);
        check_val("midrst_data", data_a, 0);
        check_val("midrst_sat", sat_a, 0);
        @(negedge clk);
        restart_model();
        rst_n_a = 1'b1;

        // Long unstalled run after reset, with output statistics.
        stream_a(2100, 0, 1'b1);
        m0  = s0 / ns;
        m1  = s1 / ns;
        sd0 = $sqrt(q0 / ns - m0 * m0);
        sd1 = $sqrt(q1 / ns - m1 * m1);
        r   = (x01 / ns - m0 * m1) / (sd0 * sd1);
        check_val("mean_i_small", (m0 < 100.0 && m0 > -100.0), 1);
        check_val("mean_q_small", (m1 < 100.0 && m1 > -100.0), 1);
        check_val("std_i_near", (sd0 > 1060.0 && sd0 < 1296.0), 1);
        check_val("std_q_near", (sd1 > 1060.0 && sd1 < 1296.0), 1);
        check_val("iq_corr_small", (r < 0.1 && r > -0.1), 1);

        // Reseed while stalled with a sample pending.
        stream_a(4, 3, 1'b0);
        check_val("pre_reseed_valid", valid_a, 1);
        reseed_a = 1'b1;
        @(negedge clk);
        reseed_a = 1'b0;
        check_val("reseed_valid", valid_a, 0);
        check_val("reseed_sat", sat_a, 0);
        restart_model();
        stream_a(1010, 0, 1'b0);
        stream_a(12, 2, 1'b0);
        check_val("reseed_drain_count", acc, adm);

        wait (b_done);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/awgn_noise_gen.md
AWGN_NOISE_GEN -- requirements
Module: awgn_noise_gen

Interface
REQ-001 SHALL have parameter DATA_W, default 12: output sample width per channel, signed two's complement; legal range 4..15.
REQ-002 SHALL have parameter NUM_CH, default 2: number of independent noise channels (I, Q, ...); legal range 1..4.
REQ-003 SHALL have parameter NUM_SRC, default 16: number of uniform LFSR sources summed per channel; power of 2, legal range 2..16.
REQ-004 SHALL have parameter MAG_W, default 8: width of the unsigned noise magnitude input.
REQ-005 SHALL have parameter OUT_SHIFT, default 2: extra arithmetic right shift applied after scaling.
REQ-006 SHALL have parameter SEED, default 32'h00C0_FFEE: base seed for all sources.
REQ-007 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-008 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-009 SHALL have port enable, input, 1 bit: when high, the generator admits new samples into the pipeline.
REQ-010 SHALL have port reseed, input, 1 bit: a single-cycle pulse that reloads all seeds and flushes the pipeline.
REQ-011 SHALL have port noise_mag, input, MAG_W bits: unsigned scale, effective gain noise_mag/2^MAG_W.
REQ-012 SHALL have port out_ready, input, 1 bit: downstream accept.
REQ-013 SHALL have port out_valid, output, 1 bit: out_data holds a valid sample set.
REQ-014 SHALL have port out_data, output, NUM_CH*DATA_W bits: channel c occupies bits [c*DATA_W +: DATA_W].
REQ-015 SHALL have port sat_count, output, 16 bits: count of accepted outputs in which at least one channel clipped.

Function
REQ-016 SHALL give each channel c NUM_SRC Fibonacci LFSRs; source k SHALL use the team's 16-entry primitive trinomial table entry k (width W, taps a, b).
REQ-017 SHALL step each LFSR as state <= {state[W-2:0], state[a-1]^state[b-1]}.
REQ-018 SHALL seed source (c,k) with the low W bits of SEED ^ ((c*16+k+1) * 32'h9E37_79B9); a seed of zero SHALL be replaced by 1.
REQ-019 SHALL use state[DATA_W-1:0] of each source, interpreted as signed, as the uniform sample.
REQ-020 SHALL implement a 3-stage pipeline: S1 registers the LFSR samples; S2 registers the sum of the NUM_SRC samples at width SUM_W = DATA_W + log2(NUM_SRC); S3 registers the output.
REQ-021 SHALL form the S3 output as sum * noise_mag (signed product, width SUM_W+MAG_W+1), arithmetically shifted right by MAG_W+OUT_SHIFT (floor), then saturated symmetrically to ±(2^(DATA_W-1)-1).
REQ-022 SHALL sample noise_mag in the cycle that S3 loads; a change in noise_mag SHALL affect only later samples.
REQ-023 SHALL advance the pipeline ("adv") when !out_valid || out_ready, and SHALL stall every stage, including the LFSRs, when adv is low.
REQ-024 SHALL step the LFSRs and set the S1 valid only when adv && enable; per-stage valid bits SHALL propagate on adv.
REQ-025 SHALL, with enable held high and out_ready high, assert out_valid exactly 3 cycles after the first enable-high edge and then on every cycle.
REQ-026 SHALL, on enable deassertion, let in-flight samples drain normally; no sample SHALL be dropped or duplicated.
REQ-027 SHALL hold out_data stable while out_valid && !out_ready.
REQ-028 SHALL, on reseed, reload all LFSR seeds, clear all valid bits, and clear sat_count in that same edge; out_valid SHALL be 0 the following cycle, an unaccepted sample SHALL be discarded, and reseed SHALL take priority over adv.
REQ-029 SHALL produce, after reseed, a sample sequence bit-identical to the sequence produced after reset.
REQ-030 SHALL register a per-sample clip flag in S3; sat_count SHALL increment on (out_valid && out_ready && clip) and hold at 16'hFFFF.
REQ-031 SHALL output exactly 0 on all channels when noise_mag = 0.

Reset
REQ-032 SHALL, while rst_n is low, drive out_valid=0, out_data=0, sat_count=0, clear all valid bits, and load all LFSRs with their seeds.
REQ-033 SHALL resume from the identical seed state on rst_n release, regardless of any activity in progress when reset was asserted.

Verification
REQ-034 SHALL cover reset: assert rst_n low mid-stream -> out_valid=0, out_data=0, sat_count=0 immediately (asynchronous).
REQ-035 SHALL cover zero magnitude: noise_mag=0, enable=1, out_ready=1 -> out_valid rises on cycle 3 and out_data=0 every cycle.
REQ-036 SHALL cover statistics: defaults, noise_mag=255, 100000 samples -> per-channel mean |m| < 20 LSB, std within 2% of 1177.8 LSB, I/Q correlation |r| < 0.02.
REQ-037 SHALL cover backpressure: out_ready low for 5 cycles with random toggling thereafter -> out_data stable while stalled, and the accepted sequence equals the golden unstalled sequence.
REQ-038 SHALL cover reseed: pulse reseed after 1000 samples, including during a stall -> out_valid=0 next cycle, sat_count=0, and the next 1000 samples equal the post-reset samples.
REQ-039 SHALL cover saturation: OUT_SHIFT=0, noise_mag=255 -> outputs clip at ±2047, sat_count tracks clips and holds at 65535 after overflow.
